// File: rtl/cutoff_freq_tracker.sv
// Sequential envelope-to-cutoff mapper: shift-add multiply, band clamp, then
// slew-limited update of the registered cutoff once per accepted sample.
module cutoff_freq_tracker #(
    parameter int unsigned SAMPLE_WIDTH   = 24,
    parameter int unsigned ENV_SHIFT      = 8,
    parameter int unsigned STRENGTH_WIDTH = 4,
    parameter int unsigned FREQ_WIDTH     = 16,
    parameter int unsigned FC_MIN         = 69,
    parameter int unsigned FC_MAX         = 1024,
    parameter int unsigned SLEW_MAX       = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_valid,
    input  logic [SAMPLE_WIDTH-1:0]   env_avg,
    input  logic [STRENGTH_WIDTH-1:0] filter_strength,
    input  logic                      sweep_down,
    input  logic                      ovr_clr,
    output logic [FREQ_WIDTH-1:0]     cutoff_freq,
    output logic                      cutoff_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned EW = SAMPLE_WIDTH - ENV_SHIFT;
    localparam int unsigned AW = EW + STRENGTH_WIDTH;
    localparam int unsigned XW = ((AW > FREQ_WIDTH) ? AW : FREQ_WIDTH) + 1;
    localparam int unsigned CW = (STRENGTH_WIDTH > 1) ? $clog2(STRENGTH_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(STRENGTH_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_CLAMP,
        S_UPDATE
    } state_t;

    state_t                      state_q, state_d;
    logic [EW-1:0]               e_q, e_d;
    logic [STRENGTH_WIDTH-1:0]   s_q, s_d;
    logic                        down_q, down_d;
    logic [AW-1:0]               acc_q, acc_d;
    logic [CW-1:0]               bit_q, bit_d;
    logic [FREQ_WIDTH-1:0]       target_q, target_d;
    logic [FREQ_WIDTH-1:0]       freq_q, freq_d;
    logic                        valid_q, valid_d;
    logic                        busy_q, busy_d;
    logic                        ovr_q, ovr_d;

    logic [AW-1:0]               pp;
    logic [XW-1:0]               acc_x;
    logic [XW-1:0]               up_sum;
    logic [FREQ_WIDTH-1:0]       diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            e_q      <= '0;
            s_q      <= '0;
            down_q   <= 1'b0;
            acc_q    <= '0;
            bit_q    <= '0;
            target_q <= '0;
            freq_q   <= FREQ_WIDTH'(FC_MIN);
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            e_q      <= e_d;
            s_q      <= s_d;
            down_q   <= down_d;
            acc_q    <= acc_d;
            bit_q    <= bit_d;
            target_q <= target_d;
            freq_q   <= freq_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (sample_valid) state_d = S_MULT;
            S_MULT:   if (bit_q == LAST_BIT) state_d = S_CLAMP;
            S_CLAMP:  state_d = S_UPDATE;
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        e_d      = e_q;
        s_d      = s_q;
        down_d   = down_q;
        acc_d    = acc_q;
        bit_d    = bit_q;
        target_d = target_q;
        freq_d   = freq_q;
        pp       = AW'(e_q) << bit_q;
        acc_x    = XW'(acc_q);
        up_sum   = XW'(FC_MIN) + acc_x;
        diff     = '0;

        case (state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    e_d    = EW'(env_avg >> ENV_SHIFT);
                    s_d    = filter_strength;
                    down_d = sweep_down;
                    acc_d  = '0;
                    bit_d  = '0;
                end
            end
            S_MULT: begin
                if (s_q[bit_q]) acc_d = acc_q + pp;
                bit_d = bit_q + 1'b1;
            end
            S_CLAMP: begin
                // Down mode compares before subtracting so no wrap can occur.
                if (down_q) begin
                    if (acc_x >= XW'(FC_MAX - FC_MIN)) target_d = FREQ_WIDTH'(FC_MIN);
                    else                               target_d = FREQ_WIDTH'(XW'(FC_MAX) - acc_x);
                end else begin
                    if (up_sum > XW'(FC_MAX)) target_d = FREQ_WIDTH'(FC_MAX);
                    else                      target_d = FREQ_WIDTH'(up_sum);
                end
            end
            S_UPDATE: begin
                if (target_q >= freq_q) begin
                    diff = target_q - freq_q;
                    if (SLEW_MAX == 0 || diff <= FREQ_WIDTH'(SLEW_MAX)) freq_d = target_q;
                    else freq_d = freq_q + FREQ_WIDTH'(SLEW_MAX);
                end else begin
                    diff = freq_q - target_q;
                    if (SLEW_MAX == 0 || diff <= FREQ_WIDTH'(SLEW_MAX)) freq_d = target_q;
                    else freq_d = freq_q - FREQ_WIDTH'(SLEW_MAX);
                end
            end
            default: ;
        endcase

        valid_d = (state_q == S_UPDATE);
        busy_d  = (state_d != S_IDLE);
        if (sample_valid && state_q != S_IDLE) ovr_d = 1'b1;
        else if (ovr_clr)                      ovr_d = 1'b0;
        else                                   ovr_d = ovr_q;
    end

    assign cutoff_freq  = freq_q;
    assign cutoff_valid = valid_q;
    assign busy         = busy_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_cutoff_freq_tracker.sv
// Directed bench for cutoff_freq_tracker: default instance plus an
// unslewed (SLEW_MAX=0) instance sharing the same stimulus.
module tb_cutoff_freq_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [23:0] env_avg;
    logic [3:0]  filter_strength;
    logic        sweep_down;
    logic        ovr_clr;

    logic [15:0] cf_a, cf_b;
    logic        cv_a, cv_b, busy_a, busy_b, ovr_a, ovr_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cutoff_freq_tracker dut_a (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .env_avg(env_avg),
        .filter_strength(filter_strength), .sweep_down(sweep_down), .ovr_clr(ovr_clr),
        .cutoff_freq(cf_a), .cutoff_valid(cv_a), .busy(busy_a), .overrun(ovr_a)
    );

    cutoff_freq_tracker #(.SLEW_MAX(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .env_avg(env_avg),
        .filter_strength(filter_strength), .sweep_down(sweep_down), .ovr_clr(ovr_clr),
        .cutoff_freq(cf_b), .cutoff_valid(cv_b), .busy(busy_b), .overrun(ovr_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept at E0, scramble operands, expect the single result at E6.
    task automatic sample(input logic [23:0] env, input logic [3:0] s, input logic dn,
                          input int exp_a, input int exp_b);
        env_avg = env; filter_strength = s; sweep_down = dn; sample_valid = 1'b1;
        tick;
        sample_valid = 1'b0;
        env_avg = ~env; filter_strength = ~s; sweep_down = ~dn;
        chk("busy_e0", busy_a, 1);
        repeat (5) tick;
        chk("valid_e5", cv_a, 0);
        tick;
        chk("valid_e6_a", cv_a, 1);
        chk("valid_e6_b", cv_b, 1);
        chk("busy_e6", busy_a, 0);
        chk("freq_a", cf_a, 32'(exp_a));
        chk("freq_b", cf_b, 32'(exp_b));
    endtask

    initial begin
        int pulses;
        int exp_a;
        rst_n = 1'b0; sample_valid = 1'b0; env_avg = '0; filter_strength = '0;
        sweep_down = 1'b0; ovr_clr = 1'b0;
        tick; tick;
        chk("rst_freq", cf_a, 69);
        chk("rst_valid", cv_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_ovr", ovr_a, 0);
        rst_n = 1'b1;
        tick;

        // zero strength, up mode: target FC_MIN
        sample(24'h001000, 4'd0, 1'b0, 69, 69);
        // up sweep, target 133
        sample(24'h001000, 4'd4, 1'b0, 101, 133);
        sample(24'h001000, 4'd4, 1'b0, 133, 133);
        sample(24'h001000, 4'd4, 1'b0, 133, 133);

        // reset at E3 aborts computation
        env_avg = 24'h001000; filter_strength = 4'd4; sweep_down = 1'b1; sample_valid = 1'b1;
        tick;
        sample_valid = 1'b0;
        repeat (3) tick;
        rst_n = 1'b0;
        #1;
        chk("abort_freq", cf_a, 69);
        chk("abort_busy", busy_a, 0);
        tick;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (cv_a || cv_b) pulses++;
        end
        chk("abort_no_valid", pulses, 0);

        // down mode, zero strength: target FC_MAX, slewed in 30 steps
        for (int k = 1; k <= 30; k++) begin
            exp_a = 69 + 32 * k;
            if (exp_a > 1024) exp_a = 1024;
            sample(24'h000000, 4'd0, 1'b1, exp_a, 1024);
        end

        // saturation
        sample(24'hFFFFFF, 4'd15, 1'b1, 992, 69);
        sample(24'hFFFFFF, 4'd15, 1'b0, 1024, 1024);

        // overrun: strobes at E0 and E3
        chk("ovr_pre", ovr_a, 0);
        env_avg = 24'h001000; filter_strength = 4'd4; sweep_down = 1'b0; sample_valid = 1'b1;
        tick;
        sample_valid = 1'b0;
        tick; tick;
        chk("ovr_e2", ovr_a, 0);
        sample_valid = 1'b1;
        tick;
        sample_valid = 1'b0;
        chk("ovr_e3", ovr_a, 1);
        tick;
        chk("ovr_e4", ovr_a, 1);
        chk("ovr_valid_e4", cv_a, 0);
        tick;
        chk("ovr_valid_e5", cv_a, 0);
        tick;
        chk("ovr_valid_e6", cv_a, 1);
        chk("ovr_freq_a", cf_a, 992);
        chk("ovr_freq_b", cf_b, 133);
        tick;
        chk("ovr_valid_e7", cv_a, 0);
        chk("ovr_busy_e7", busy_a, 0);
        tick; tick;
        ovr_clr = 1'b1;
        tick;
        ovr_clr = 1'b0;
        chk("ovr_clr_e10", ovr_a, 0);

        // clear coincident with dropped strobe: set wins
        sample_valid = 1'b1;
        tick;
        sample_valid = 1'b0;
        tick;
        sample_valid = 1'b1; ovr_clr = 1'b1;
        tick;
        sample_valid = 1'b0; ovr_clr = 1'b0;
        chk("ovr_set_wins", ovr_a, 1);
        repeat (4) tick;
        chk("ovr2_valid_e6", cv_a, 1);
        chk("ovr2_freq_a", cf_a, 960);
        ovr_clr = 1'b1;
        tick;
        ovr_clr = 1'b0;
        chk("ovr_clr2", ovr_a, 0);

        // back-to-back: strobe held high, accepts every 7 cycles
        sample_valid = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            tick;
            if (i == 1) chk("b2b_ovr_e1", ovr_a, 1);
            chk("b2b_valid", cv_a, ((i % 7) == 6) ? 1 : 0);
            if (i == 7 || i == 14) chk("b2b_busy", busy_a, 1);
        end
        sample_valid = 1'b0;
        chk("b2b_freq_a", cf_a, 864);
        chk("b2b_freq_b", cf_b, 133);
        tick; tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
